// File: rtl/instr_image_encoder.sv
// Encodes symbolic MIPS instruction fields into 32-bit words and streams them
// into instruction memory, one word per accepted request, during a load session.
module instr_image_encoder #(
    parameter int          DEPTH = 128,
    parameter logic [31:0] BASE  = 32'h0000_0000,
    parameter int          CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          start,
    input  logic          finish,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [4:0]    in_mnem,
    input  logic [4:0]    in_rs,
    input  logic [4:0]    in_rt,
    input  logic [4:0]    in_rd,
    input  logic [4:0]    in_shamt,
    input  logic [15:0]   in_imm,
    input  logic [25:0]   in_target,
    output logic          im_we,
    output logic [31:0]   im_addr,
    output logic [31:0]   im_wdata,
    output logic [CW-1:0] word_count,
    output logic [7:0]    illegal_cnt,
    output logic          busy,
    output logic          done
);

    typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

    state_t state, state_nxt;
    logic   accept, legal, acc_legal, acc_illegal, clear, full_nxt;
    logic   vld_p1;
    logic [31:0] addr_p1, wdata_p1;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    function automatic logic [31:0] encode(
        input logic [4:0]  mnem,
        input logic [4:0]  rs,
        input logic [4:0]  rt,
        input logic [4:0]  rd,
        input logic [4:0]  shamt,
        input logic [15:0] imm,
        input logic [25:0] target
    );
        logic [5:0]  funct;
        logic [5:0]  op;
        logic [31:0] w;
        funct = 6'h00;
        op    = 6'h00;
        case (mnem)
            5'd0:    funct = 6'h20;
            5'd1:    funct = 6'h22;
            5'd2:    funct = 6'h24;
            5'd3:    funct = 6'h25;
            5'd4:    funct = 6'h2A;
            5'd5:    funct = 6'h2B;
            5'd6:    funct = 6'h21;
            5'd7:    funct = 6'h23;
            5'd8:    funct = 6'h00;
            5'd9:    funct = 6'h27;
            5'd10:   op = 6'h08;
            5'd11:   op = 6'h0D;
            5'd12:   op = 6'h23;
            5'd13:   op = 6'h2B;
            5'd14:   op = 6'h04;
            5'd15:   op = 6'h0F;
            5'd16:   op = 6'h0A;
            5'd17:   op = 6'h02;
            5'd18:   op = 6'h03;
            5'd19:   op = 6'h05;
            default: op = 6'h00;
        endcase
        // sll is the only R-type that uses shamt, and it has no rs operand
        if (mnem < 5'd10)
            w = {6'h00, (mnem == 5'd8) ? 5'd0 : rs, rt, rd,
                 (mnem == 5'd8) ? shamt : 5'd0, funct};
        else if (mnem == 5'd17 || mnem == 5'd18)
            w = {op, target};
        else
            w = {op, (mnem == 5'd15) ? 5'd0 : rs, rt, imm};
        return w;
    endfunction

    assign busy        = (state == LOAD);
    assign done        = (state == DONE);
    assign in_ready    = busy && (word_count < CW'(DEPTH)) && !finish;
    assign accept      = in_valid && in_ready;
    assign legal       = (in_mnem < 5'd20);
    assign acc_legal   = accept && legal;
    assign acc_illegal = accept && !legal;
    assign clear       = start && (state != LOAD);
    assign full_nxt    = acc_legal && (word_count == CW'(DEPTH - 1));

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = LOAD;
            LOAD:    if (finish || full_nxt || word_count == CW'(DEPTH)) state_nxt = DONE;
            DONE:    if (start) state_nxt = LOAD;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            word_count  <= '0;
            illegal_cnt <= '0;
        end else if (clear) begin
            word_count  <= '0;
            illegal_cnt <= '0;
        end else begin
            if (acc_legal)   word_count  <= word_count + 1'b1;
            if (acc_illegal) illegal_cnt <= sat_inc8(illegal_cnt);
        end
    end

    // stage p0 -> p1: encoded word registered toward instruction memory
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            vld_p1   <= 1'b0;
            addr_p1  <= '0;
            wdata_p1 <= '0;
        end else begin
            vld_p1 <= acc_legal;
            if (acc_legal) begin
                addr_p1  <= BASE + (32'(word_count) << 2);
                wdata_p1 <= encode(in_mnem, in_rs, in_rt, in_rd, in_shamt, in_imm, in_target);
            end
        end
    end

    assign im_we    = vld_p1;
    assign im_addr  = addr_p1;
    assign im_wdata = wdata_p1;

endmodule

// File: tb/tb_instr_image_encoder.sv
// Bench for instr_image_encoder: two instances (DEPTH 128 and 4) share stimulus
// and are checked every cycle against a behavioural session/encoding model.
module tb_instr_image_encoder;

    localparam logic [31:0] BASE = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        start = 1'b0;
    logic        finish = 1'b0;
    logic        in_valid = 1'b0;
    logic [4:0]  in_mnem = '0, in_rs = '0, in_rt = '0, in_rd = '0, in_shamt = '0;
    logic [15:0] in_imm = '0;
    logic [25:0] in_target = '0;

    logic        rdy [2];
    logic        we [2];
    logic [31:0] addr [2];
    logic [31:0] wdata [2];
    logic [7:0]  ill [2];
    logic        bsy [2];
    logic        dn [2];
    logic [7:0]  wc0;
    logic [2:0]  wc1;

    instr_image_encoder #(.DEPTH(128), .BASE(BASE)) dut_big (
        .clk(clk), .rstn(rstn), .start(start), .finish(finish),
        .in_valid(in_valid), .in_ready(rdy[0]), .in_mnem(in_mnem),
        .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_shamt(in_shamt),
        .in_imm(in_imm), .in_target(in_target),
        .im_we(we[0]), .im_addr(addr[0]), .im_wdata(wdata[0]),
        .word_count(wc0), .illegal_cnt(ill[0]), .busy(bsy[0]), .done(dn[0])
    );

    instr_image_encoder #(.DEPTH(4), .BASE(BASE)) dut_small (
        .clk(clk), .rstn(rstn), .start(start), .finish(finish),
        .in_valid(in_valid), .in_ready(rdy[1]), .in_mnem(in_mnem),
        .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_shamt(in_shamt),
        .in_imm(in_imm), .in_target(in_target),
        .im_we(we[1]), .im_addr(addr[1]), .im_wdata(wdata[1]),
        .word_count(wc1), .illegal_cnt(ill[1]), .busy(bsy[1]), .done(dn[1])
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int dep [2] = '{128, 4};

    // model: mode 0 idle, 1 loading, 2 closed
    int          m_mode [2];
    int          m_cnt [2];
    int          m_ill [2];
    bit          m_we [2];
    logic [31:0] m_addr [2];
    logic [31:0] m_data [2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_enc(input int m, input int rs, input int rt,
                                            input int rd, input int sh, input int imm,
                                            input int tgt);
        int funct_tab [10] = '{32, 34, 36, 37, 42, 43, 33, 35, 0, 39};
        int op_tab [20] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 8, 13, 35, 43, 4, 15, 10, 2, 3, 5};
        longint w;
        if (m < 10) begin
            if (m == 8) rs = 0;
            else        sh = 0;
            w = longint'(rs) * 2097152 + longint'(rt) * 65536 + longint'(rd) * 2048
                + longint'(sh) * 64 + funct_tab[m];
        end else if (m == 17 || m == 18) begin
            w = longint'(op_tab[m]) * 67108864 + tgt;
        end else begin
            if (m == 15) rs = 0;
            w = longint'(op_tab[m]) * 67108864 + longint'(rs) * 2097152
                + longint'(rt) * 65536 + imm;
        end
        return 32'(w);
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_mode[d] = 0; m_cnt[d] = 0; m_ill[d] = 0;
            m_we[d] = 0; m_addr[d] = '0; m_data[d] = '0;
        end
    endtask

    task automatic model_edge();
        bit acc, lg;
        if (!rstn) begin
            model_reset();
            return;
        end
        for (int d = 0; d < 2; d++) begin
            acc = (m_mode[d] == 1) && (m_cnt[d] < dep[d]) && !finish && in_valid;
            lg  = (in_mnem < 20);
            m_we[d] = 0;
            if (acc && lg) begin
                m_we[d]   = 1;
                m_addr[d] = BASE + 32'(4 * m_cnt[d]);
                m_data[d] = ref_enc(in_mnem, in_rs, in_rt, in_rd, in_shamt, in_imm, in_target);
                m_cnt[d]++;
            end
            if (acc && !lg && m_ill[d] < 255) m_ill[d]++;
            if (m_mode[d] != 1 && start) begin
                m_mode[d] = 1; m_cnt[d] = 0; m_ill[d] = 0;
            end else if (m_mode[d] == 1 && (finish || m_cnt[d] == dep[d])) begin
                m_mode[d] = 2;
            end
        end
    endtask

    task automatic check_all();
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("d%0d_im_we", d), 32'(we[d]), 32'(m_we[d]));
            chk($sformatf("d%0d_im_addr", d), addr[d], m_addr[d]);
            chk($sformatf("d%0d_im_wdata", d), wdata[d], m_data[d]);
            chk($sformatf("d%0d_word_count", d), (d == 0) ? 32'(wc0) : 32'(wc1), 32'(m_cnt[d]));
            chk($sformatf("d%0d_illegal_cnt", d), 32'(ill[d]), 32'(m_ill[d]));
            chk($sformatf("d%0d_busy", d), 32'(bsy[d]), 32'(m_mode[d] == 1));
            chk($sformatf("d%0d_done", d), 32'(dn[d]), 32'(m_mode[d] == 2));
        end
    endtask

    task automatic step(input bit rst_mid);
        #1;
        for (int d = 0; d < 2; d++)
            chk($sformatf("d%0d_in_ready", d), 32'(rdy[d]),
                32'((m_mode[d] == 1) && (m_cnt[d] < dep[d]) && !finish));
        @(posedge clk);
        model_edge();
        if (rst_mid) begin
            #1;
            rstn = 1'b0;
            model_reset();
        end
        #1;
        check_all();
    endtask

    task automatic req(input int m, input int rs, input int rt, input int rd,
                       input int sh, input int imm, input int tgt);
        in_valid = 1'b1;
        in_mnem = 5'(m); in_rs = 5'(rs); in_rt = 5'(rt); in_rd = 5'(rd);
        in_shamt = 5'(sh); in_imm = 16'(imm); in_target = 26'(tgt);
    endtask

    task automatic pulse_start();
        start = 1'b1; step(0); start = 1'b0;
    endtask

    task automatic pulse_finish();
        finish = 1'b1; step(0); finish = 1'b0;
    endtask

    initial begin
        model_reset();
        step(0);
        step(0);
        rstn = 1'b1;

        // single add
        pulse_start();
        req(0, 1, 2, 3, 0, 0, 0); step(0);
        chk("t1_we", 32'(we[0]), 32'd1);
        chk("t1_addr", addr[0], 32'h0);
        chk("t1_data", wdata[0], 32'h00221820);
        in_valid = 1'b0; step(0);
        chk("t1_we_drop", 32'(we[0]), 32'd0);

        // back-to-back addi / lw in a fresh session
        pulse_finish();
        pulse_start();
        req(10, 0, 1, 0, 0, 5, 0); step(0);
        chk("t2_addi", wdata[0], 32'h20010005);
        req(12, 1, 2, 0, 0, 4, 0); step(0);
        chk("t2_lw", wdata[0], 32'h8C220004);
        chk("t2_lw_addr", addr[0], 32'h4);

        // forced-field encodings
        req(8, 7, 1, 2, 4, 0, 0); step(0);
        chk("t3_sll", wdata[0], 32'h00011100);
        req(15, 5, 1, 0, 0, 16'h1234, 0); step(0);
        chk("t3_lui", wdata[0], 32'h3C011234);
        req(14, 1, 2, 0, 0, 16'hFFFF, 0); step(0);
        chk("t3_beq", wdata[0], 32'h1022FFFF);
        req(17, 0, 0, 0, 0, 0, 26'h100); step(0);
        chk("t3_j", wdata[0], 32'h08000100);
        in_valid = 1'b0; step(0);
        chk("t2_count", 32'(wc0), 32'd6);

        // illegal mnemonics and saturation
        pulse_finish();
        pulse_start();
        req(25, 1, 2, 3, 4, 5, 6); step(0);
        chk("t4_no_we", 32'(we[0]), 32'd0);
        chk("t4_ill1", 32'(ill[0]), 32'd1);
        chk("t4_wc", 32'(wc0), 32'd0);
        repeat (255) step(0);
        chk("t4_ill_sat", 32'(ill[0]), 32'd255);

        // fill the DEPTH=4 instance
        in_valid = 1'b0;
        pulse_finish();
        pulse_start();
        req(6, 3, 4, 5, 0, 0, 0);
        repeat (5) step(0);
        chk("t5_small_wc", 32'(wc1), 32'd4);
        chk("t5_small_done", 32'(dn[1]), 32'd1);
        chk("t5_small_ready", 32'(rdy[1]), 32'd0);
        chk("t5_big_wc", 32'(wc0), 32'd5);

        // async reset while a write is pending
        req(1, 9, 8, 7, 0, 0, 0);
        step(1);
        chk("t6_we", 32'(we[0]), 32'd0);
        chk("t6_busy", 32'(bsy[0]), 32'd0);
        chk("t6_wc", 32'(wc0), 32'd0);
        in_valid = 1'b0;
        rstn = 1'b1;
        step(0);
        pulse_start();
        step(0);
        pulse_finish();
        chk("t6_done", 32'(dn[0]), 32'd1);

        // randomized sessions
        repeat (400) begin
            start    = ($urandom % 25) == 0;
            finish   = ($urandom % 25) == 0;
            in_valid = ($urandom % 3) != 0;
            in_mnem  = (($urandom % 8) == 0) ? 5'($urandom_range(20, 31)) : 5'($urandom_range(0, 19));
            in_rs = 5'($urandom); in_rt = 5'($urandom); in_rd = 5'($urandom);
            in_shamt = 5'($urandom); in_imm = 16'($urandom); in_target = 26'($urandom);
            step(0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
